// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes and select encodings for the multi-cycle MIPS control unit
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF  = 5'd0,  S_ID  = 5'd1,  S_EXR = 5'd2,  S_EXS = 5'd3,
        S_WBR = 5'd4,  S_EXI = 5'd5,  S_WBI = 5'd6,  S_LUI = 5'd7,
        S_MA  = 5'd8,  S_MR  = 5'd9,  S_MW  = 5'd10, S_WBM = 5'd11,
        S_BR  = 5'd12, S_J   = 5'd13, S_JAL = 5'd14, S_JR  = 5'd15,
        S_ERR = 5'd16
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e, OP_LUI  = 6'h0f, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD   = 3'b010, ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100, ALU_SHIFT = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT  = 2'b00, RD_RD  = 2'b01, RD_RA  = 2'b10;
    localparam logic [1:0] DR_ALU = 2'b00, DR_MDR = 2'b01, DR_LUI = 2'b10, DR_PC = 2'b11;
    localparam logic [1:0] SA_PC  = 2'b00, SA_RS  = 2'b01, SA_RT  = 2'b10;
    localparam logic [1:0] SB_RT  = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_OFFSET = 2'b11;
    localparam logic [1:0] PS_ALU = 2'b00, PS_ALUOUT = 2'b01, PS_JUMP = 2'b10;

    function automatic logic is_signed_imm(input logic [5:0] opcode);
        return (opcode == OP_ADDI) || (opcode == OP_SLTI);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - maps R-type funct or I-type opcode onto the ALU operation code
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_SLTI: alu_op = ALU_SLT;
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_XORI: alu_op = ALU_XOR;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control FSM driving datapath selects and memory strobes
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [4:0] RESET_STATE    = 5'd0,
    parameter bit         NOP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_ready,
    input  logic [31:0] Inst,
    input  logic        zero,
    output logic        IorD,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic [1:0]  DatatoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic        Sign,
    output logic [2:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [4:0]  state,
    output logic        illegal
);

    state_t      cur;
    state_t      dispatch;
    logic        legal;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [2:0]  dec_op;
    logic        unused_bits;

    assign opcode      = Inst[31:26];
    assign funct       = Inst[5:0];
    assign state       = cur;
    assign unused_bits = ^{zero, Inst[25:6]};

    mc_alu_dec u_alu_dec (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_op)
    );

    always_comb begin
        dispatch = S_IF;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT:     dispatch = S_EXR;
                    FN_SLL, FN_SRL, FN_SRA:     dispatch = S_EXS;
                    FN_JR:                      dispatch = S_JR;
                    default:                    legal    = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI:                    dispatch = S_EXI;
            OP_LUI:                             dispatch = S_LUI;
            OP_LW, OP_SW:                       dispatch = S_MA;
            OP_BEQ, OP_BNE:                     dispatch = S_BR;
            OP_J:                               dispatch = S_J;
            OP_JAL:                             dispatch = S_JAL;
            default:                            legal    = 1'b0;
        endcase
        if (!legal)
            dispatch = NOP_ON_ILLEGAL ? S_IF : S_ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= state_t'(RESET_STATE);
        end else begin
            case (cur)
                S_IF:                 if (MIO_ready) cur <= S_ID;
                S_ID:                 cur <= dispatch;
                S_EXR, S_EXS:         cur <= S_WBR;
                S_EXI:                cur <= S_WBI;
                S_MA:                 cur <= (opcode == OP_SW) ? S_MW : S_MR;
                S_MR:                 if (MIO_ready) cur <= S_WBM;
                S_MW:                 if (MIO_ready) cur <= S_IF;
                S_ERR:                cur <= S_ERR;
                default:              cur <= S_IF;
            endcase
        end
    end

    // Memory wait states keep the address-generation selects so ALUOut stays stable.
    always_comb begin
        IorD = 1'b0; IRWrite = 1'b0; RegDst = RD_RT; RegWrite = 1'b0;
        DatatoReg = DR_ALU; ALUSrcA = SA_PC; ALUSrcB = SB_RT; PCSource = PS_ALU;
        PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0; Sign = 1'b0;
        ALU_operation = ALU_AND; MemRead = 1'b0; MemWrite = 1'b0; illegal = 1'b0;
        case (cur)
            S_IF: begin
                MemRead = 1'b1; ALUSrcB = SB_FOUR; ALU_operation = ALU_ADD;
                PCWrite = 1'b1; IRWrite = MIO_ready;
            end
            S_ID: begin
                ALUSrcB = SB_OFFSET; Sign = 1'b1; ALU_operation = ALU_ADD; illegal = !legal;
            end
            S_EXR: begin
                ALUSrcA = SA_RS; ALU_operation = dec_op;
            end
            S_EXS: begin
                ALUSrcA = SA_RT; ALUSrcB = SB_IMM; ALU_operation = ALU_SHIFT;
            end
            S_WBR: begin
                RegDst = RD_RD; RegWrite = 1'b1;
            end
            S_EXI: begin
                ALUSrcA = SA_RS; ALUSrcB = SB_IMM; ALU_operation = dec_op;
                Sign = is_signed_imm(opcode);
            end
            S_WBI: begin
                RegWrite = 1'b1; Sign = is_signed_imm(opcode);
            end
            S_LUI: begin
                DatatoReg = DR_LUI; RegWrite = 1'b1;
            end
            S_MA, S_MR, S_MW: begin
                ALUSrcA = SA_RS; ALUSrcB = SB_IMM; Sign = 1'b1; ALU_operation = ALU_ADD;
                IorD = (cur != S_MA); MemRead = (cur == S_MR); MemWrite = (cur == S_MW);
            end
            S_WBM: begin
                DatatoReg = DR_MDR; RegWrite = 1'b1;
            end
            S_BR: begin
                ALUSrcA = SA_RS; ALU_operation = ALU_SUB; PCSource = PS_ALUOUT;
                PCWriteCond = 1'b1; Branch = (opcode == OP_BEQ);
            end
            S_J: begin
                PCSource = PS_JUMP; PCWrite = 1'b1;
            end
            S_JAL: begin
                RegDst = RD_RA; DatatoReg = DR_PC; RegWrite = 1'b1;
                PCSource = PS_JUMP; PCWrite = 1'b1;
            end
            S_JR: begin
                ALUSrcA = SA_RS; ALU_operation = ALU_ADD; PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized instruction stream checked against a class-level control model
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic iord; logic irw; logic [1:0] rdst; logic rw; logic [1:0] d2r;
        logic [1:0] asa; logic [1:0] asb; logic [1:0] pcs; logic pcw; logic pcwc;
        logic br; logic sgn; logic [2:0] aop; logic mr; logic mw; logic ill;
    } ctrl_t;

    typedef enum {C_R, C_SH, C_JR, C_IS, C_IU, C_LUI, C_LW, C_SW,
                  C_BEQ, C_BNE, C_J, C_JAL, C_ILL} cls_t;

    logic clk = 1'b0, reset, MIO_ready, zero;
    logic [31:0] Inst;
    logic IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch, Sign, MemRead, MemWrite, illegal;
    logic [1:0] RegDst, DatatoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [2:0] ALU_operation;
    logic [4:0] state;
    logic e_IorD, e_IRWrite, e_RegWrite, e_PCWrite, e_PCWriteCond, e_Branch, e_Sign;
    logic e_MemRead, e_MemWrite, e_illegal;
    logic [1:0] e_RegDst, e_DatatoReg, e_ALUSrcA, e_ALUSrcB, e_PCSource;
    logic [2:0] e_ALU_operation;
    logic [4:0] e_state;
    ctrl_t ctrl, e_ctrl;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm u_dut (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
        .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .DatatoReg(DatatoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .Sign(Sign),
        .ALU_operation(ALU_operation), .MemRead(MemRead), .MemWrite(MemWrite),
        .state(state), .illegal(illegal)
    );

    mc_ctrl_fsm #(.NOP_ON_ILLEGAL(1'b0)) u_dut_err (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
        .IorD(e_IorD), .IRWrite(e_IRWrite), .RegDst(e_RegDst), .RegWrite(e_RegWrite),
        .DatatoReg(e_DatatoReg), .ALUSrcA(e_ALUSrcA), .ALUSrcB(e_ALUSrcB), .PCSource(e_PCSource),
        .PCWrite(e_PCWrite), .PCWriteCond(e_PCWriteCond), .Branch(e_Branch), .Sign(e_Sign),
        .ALU_operation(e_ALU_operation), .MemRead(e_MemRead), .MemWrite(e_MemWrite),
        .state(e_state), .illegal(e_illegal)
    );

    assign ctrl = {IorD, IRWrite, RegDst, RegWrite, DatatoReg, ALUSrcA, ALUSrcB, PCSource,
                   PCWrite, PCWriteCond, Branch, Sign, ALU_operation, MemRead, MemWrite, illegal};
    assign e_ctrl = {e_IorD, e_IRWrite, e_RegDst, e_RegWrite, e_DatatoReg, e_ALUSrcA, e_ALUSrcB,
                     e_PCSource, e_PCWrite, e_PCWriteCond, e_Branch, e_Sign, e_ALU_operation,
                     e_MemRead, e_MemWrite, e_illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] i);
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a: return C_R;
                6'h00, 6'h02, 6'h03: return C_SH;
                6'h08: return C_JR;
                default: return C_ILL;
            endcase
            6'h08, 6'h0a: return C_IS;
            6'h0c, 6'h0d, 6'h0e: return C_IU;
            6'h0f: return C_LUI;
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] ref_alu(input cls_t c, input logic [31:0] i);
        if (c == C_R) begin
            case (i[5:0])
                6'h22: return 3'b110;
                6'h24: return 3'b000;
                6'h25: return 3'b001;
                6'h26: return 3'b011;
                6'h27: return 3'b100;
                6'h2a: return 3'b111;
                default: return 3'b010;
            endcase
        end
        case (i[31:26])
            6'h0a: return 3'b111;
            6'h0c: return 3'b000;
            6'h0d: return 3'b001;
            6'h0e: return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input state_t st, input cls_t c, input logic [31:0] i,
                                       input logic rdy);
        ctrl_t e = '0;
        case (st)
            S_IF:  begin e.mr = 1; e.asb = 2'b01; e.aop = 3'b010; e.pcw = 1; e.irw = rdy; end
            S_ID:  begin e.asb = 2'b11; e.sgn = 1; e.aop = 3'b010; e.ill = (c == C_ILL); end
            S_EXR: begin e.asa = 2'b01; e.aop = ref_alu(c, i); end
            S_EXS: begin e.asa = 2'b10; e.asb = 2'b10; e.aop = 3'b101; end
            S_WBR: begin e.rdst = 2'b01; e.rw = 1; end
            S_EXI: begin e.asa = 2'b01; e.asb = 2'b10; e.aop = ref_alu(c, i); e.sgn = (c == C_IS); end
            S_WBI: begin e.rw = 1; e.sgn = (c == C_IS); end
            S_LUI: begin e.d2r = 2'b10; e.rw = 1; end
            S_MA, S_MR, S_MW: begin
                e.asa = 2'b01; e.asb = 2'b10; e.sgn = 1; e.aop = 3'b010;
                e.iord = (st != S_MA); e.mr = (st == S_MR); e.mw = (st == S_MW);
            end
            S_WBM: begin e.d2r = 2'b01; e.rw = 1; end
            S_BR:  begin e.asa = 2'b01; e.aop = 3'b110; e.pcs = 2'b01; e.pcwc = 1; e.br = (c == C_BEQ); end
            S_J:   begin e.pcs = 2'b10; e.pcw = 1; end
            S_JAL: begin e.rdst = 2'b10; e.d2r = 2'b11; e.rw = 1; e.pcs = 2'b10; e.pcw = 1; end
            S_JR:  begin e.asa = 2'b01; e.aop = 3'b010; e.pcw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input state_t st, input logic [31:0] i, input logic rdy);
        @(negedge clk);
        Inst = i; MIO_ready = rdy; zero = 1'($urandom);
        #1;
        check($sformatf("state %h", i), {27'd0, state}, {27'd0, st});
        check($sformatf("ctrl %s %h", st.name(), i), {9'd0, ctrl},
              {9'd0, exp_ctrl(st, classify(i), i, rdy)});
    endtask

    task automatic run_inst(input logic [31:0] i, input int w_if, input int w_mem);
        cls_t c = classify(i);
        state_t path[$];
        int waits;
        logic rdy;
        path = '{S_IF, S_ID};
        case (c)
            C_R:          path = {path, S_EXR, S_WBR};
            C_SH:         path = {path, S_EXS, S_WBR};
            C_IS, C_IU:   path = {path, S_EXI, S_WBI};
            C_LUI:        path.push_back(S_LUI);
            C_LW:         path = {path, S_MA, S_MR, S_WBM};
            C_SW:         path = {path, S_MA, S_MW};
            C_BEQ, C_BNE: path.push_back(S_BR);
            C_J:          path.push_back(S_J);
            C_JAL:        path.push_back(S_JAL);
            C_JR:         path.push_back(S_JR);
            default: ;
        endcase
        foreach (path[k]) begin
            waits = (path[k] == S_IF) ? w_if : (path[k] == S_MR || path[k] == S_MW) ? w_mem : 0;
            for (int w = 0; w <= waits; w++) begin
                if (path[k] == S_IF || path[k] == S_MR || path[k] == S_MW) rdy = (w == waits);
                else rdy = 1'($urandom);
                step(path[k], i, rdy);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; MIO_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [5:0] ops [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a,
                             6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
    logic [5:0] fns [11] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22,
                             6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};

    initial begin
        logic [31:0] r;
        logic [5:0] op, fn;
        reset = 1'b1; MIO_ready = 1'b0; Inst = 32'd0; zero = 1'b0;
        @(negedge clk); #1;
        check("reset state", {27'd0, state}, 32'd0);
        check("reset ctrl rdy0", {9'd0, ctrl}, {9'd0, exp_ctrl(S_IF, C_R, 32'd0, 1'b0)});
        MIO_ready = 1'b1; #1;
        check("reset ctrl rdy1", {9'd0, ctrl}, {9'd0, exp_ctrl(S_IF, C_R, 32'd0, 1'b1)});
        check("reset err state", {27'd0, e_state}, 32'd0);
        MIO_ready = 1'b0;
        @(negedge clk); reset = 1'b0;

        run_inst(32'h20010005, 0, 0);
        run_inst(32'h8C220004, 0, 2);
        run_inst(32'h10000003, 1, 0);
        run_inst(32'h14000003, 0, 0);
        run_inst(32'h0C000010, 0, 0);
        run_inst(32'h03E00008, 0, 0);
        run_inst(32'h00221820, 2, 0);
        run_inst(32'h00011080, 0, 0);
        run_inst(32'h3C011234, 0, 0);
        run_inst(32'h30210007, 0, 0);
        run_inst(32'h08000010, 0, 0);
        run_inst(32'hAC220004, 1, 1);

        // sw interrupted by reset while the write strobe is up
        step(S_IF, 32'hAC220004, 1'b1);
        step(S_ID, 32'hAC220004, 1'b0);
        step(S_MA, 32'hAC220004, 1'b1);
        step(S_MW, 32'hAC220004, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async reset state", {27'd0, state}, 32'd0);
        check("async reset MemWrite", {31'd0, MemWrite}, 32'd0);
        check("async reset MemRead", {31'd0, MemRead}, 32'd1);
        @(negedge clk); reset = 1'b0; MIO_ready = 1'b0;
        run_inst(32'h20010005, 0, 0);

        run_inst(32'hFC000000, 0, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); MIO_ready = 1'b1; #1;
            check("err state", {27'd0, e_state}, {27'd0, S_ERR});
            check("err ctrl", {9'd0, e_ctrl}, 32'd0);
        end
        do_reset();

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            op = ($urandom_range(0, 9) == 0) ? r[31:26] : ops[$urandom_range(0, 12)];
            fn = ($urandom_range(0, 9) == 0) ? r[5:0] : fns[$urandom_range(0, 10)];
            run_inst({op, r[25:6], fn}, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit sitting directly upstream of the multi-cycle datapath.
- Decodes the datapath's IR (Inst) and sequences fetch/decode/execute/memory/writeback.
- Drives every datapath control select plus memory-bus strobes (MemRead/MemWrite).
- Stalls on MIO_ready for all memory transactions.

Parameters:
- RESET_STATE, 5'd0 (S_IF), state entered on reset.
- NOP_ON_ILLEGAL, 1, 1 = undefined opcode/funct returns to S_IF and pulses illegal; 0 = park in S_ERR until reset.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- MIO_ready  in  1  memory/IO transaction complete this cycle
- Inst  in  32  current IR contents from datapath
- zero  in  1  ALU zero flag (observed only via datapath CE; unused internally)
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  load IR
- RegDst  out  2  00 rt, 01 rd, 10 $31
- RegWrite  out  1  register-file write
- DatatoReg  out  2  00 ALUOut, 01 MDR, 10 lui, 11 PC
- ALUSrcA  out  2  00 PC, 01 rs, 10 rt, 11 zero
- ALUSrcB  out  2  00 rt, 01 const 4, 10 Imm_32, 11 offset
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load
- Branch  out  1  1 = take on zero (beq), 0 = take on !zero (bne)
- Sign  out  1  sign-extend immediate
- ALU_operation  out  3  per package encoding
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- state  out  5  current state (debug)
- illegal  out  1  one-cycle pulse on undefined instruction

Behaviour:
- Moore FSM: state register only; outputs are combinational from state plus IR fields. Only IRWrite additionally depends on MIO_ready.
- Reset: state = S_IF. All outputs take S_IF values: MemRead=1, ALUSrcB=01, ALU_operation=ADD, PCWrite=1, IRWrite=MIO_ready; everything else 0.
- Unlisted outputs are 0 in every state.
- S_IF: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ADD, PCSource=00, PCWrite=1, IRWrite=MIO_ready.
  - Hold while !MIO_ready (datapath gates PC with MIO_ready).
  - Go to S_ID on ready.
- S_ID: ALUSrcA=00, ALUSrcB=11, Sign=1, ADD; ALUOut gets branch target. Dispatch on opcode/funct:
  - R-ALU -> S_EXR; sll/srl/sra -> S_EXS; jr -> S_JR
  - addi/slti -> S_EXI (Sign=1); andi/ori/xori -> S_EXI (Sign=0)
  - lui -> S_LUI; lw/sw -> S_MA; beq/bne -> S_BR; j -> S_J; jal -> S_JAL
  - else -> illegal handling
- S_EXR: ALUSrcA=01, ALUSrcB=00, op from funct. -> S_WBR.
- S_EXS: ALUSrcA=10, ALUSrcB=10, Sign=0, op=SHIFT (ALU takes shamt/direction from Imm_32). -> S_WBR.
- S_WBR: RegDst=01, DatatoReg=00, RegWrite=1. -> S_IF.
- S_EXI: ALUSrcA=01, ALUSrcB=10, op from opcode. -> S_WBI.
- S_WBI: RegDst=00, DatatoReg=00, RegWrite=1. -> S_IF.
- S_LUI: RegDst=00, DatatoReg=10, RegWrite=1. -> S_IF.
- S_MA: ALUSrcA=01, ALUSrcB=10, Sign=1, ADD. -> S_MR (lw) or S_MW (sw).
- S_MR and S_MW: IorD=1 and the S_MA ALU selects held so ALUOut stays stable across wait cycles.
  - S_MR: MemRead=1; hold until MIO_ready, then -> S_WBM.
  - S_MW: MemWrite=1; hold until MIO_ready, then -> S_IF.
- S_WBM: RegDst=00, DatatoReg=01, RegWrite=1. -> S_IF.
- S_BR: ALUSrcA=01, ALUSrcB=00, SUB, PCSource=01, PCWriteCond=1, Branch=(opcode==beq). -> S_IF.
- S_J: PCSource=10, PCWrite=1. -> S_IF.
- S_JAL: RegDst=10, DatatoReg=11, RegWrite=1, PCSource=10, PCWrite=1. -> S_IF. PC already equals PC+4, so $31 = PC+4.
- S_JR: ALUSrcA=01, ALUSrcB=00 (rt=$0), ADD, PCSource=00, PCWrite=1. -> S_IF.
- Illegal instruction: illegal=1 for exactly the S_ID cycle.
  - NOP_ON_ILLEGAL=1: -> S_IF.
  - NOP_ON_ILLEGAL=0: -> S_ERR, all outputs 0 until reset.
- Latency in cycles with zero wait states: R/I/lui 4 (lui 3), lw 5, sw 4, branch/j/jal/jr 3. Each MIO wait adds 1.
- Reset mid-instruction: immediate return to S_IF; no partial RegWrite/MemWrite after reset deasserts.

Decomposition:
- Package mc_ctrl_pkg:
  - State localparams S_IF..S_ERR.
  - Opcode/funct constants.
  - ALU_operation encoding: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SHIFT 101, SUB 110, SLT 111.
  - Select encodings for RegDst/DatatoReg/ALUSrcA/ALUSrcB/PCSource.
- Sub-module mc_alu_dec: combinational funct/opcode -> ALU_operation, used in S_EXR/S_EXI.

Test Plan:
- Reset asserted in S_MW with MemWrite=1 -> state=0 and MemWrite=0 within the same cycle (async); next instruction fetched from S_IF.
- Inst=0x20010005 (addi $1,$0,5), MIO_ready=1 -> IF,ID,EXI,WBI; WBI shows RegDst=00, RegWrite=1, Sign=1; ALU_operation=010 in EXI.
- Inst=0x8C220004 (lw), MIO_ready low 2 cycles in S_MR -> S_MR held 3 cycles with IorD=1 and ALU selects constant; then S_WBM with DatatoReg=01; 7 cycles total.
- Inst=0x10000003 (beq) -> S_BR with Branch=1, PCWriteCond=1, PCSource=01, ALU_operation=110; Inst=0x14000003 (bne) -> Branch=0.
- Inst=0x0C000010 (jal), then 0x03E00008 (jr $31) -> S_JAL: RegDst=10, DatatoReg=11, PCSource=10; S_JR: ALUSrcA=01, ALUSrcB=00, PCSource=00, PCWrite=1.
- Inst=0xFC000000 -> illegal high one cycle in S_ID, then S_IF (NOP_ON_ILLEGAL=1); with 0 -> state=S_ERR, all outputs 0.
